sprite_loader: RTL
==================

Name: sprite_loader

Overview:
- Writer side of the sprite ROM/RAM image format: accepts a 16-bit word stream (valid/ready) and writes it into sprite memory through a synchronous write port.
- Image layout is fixed: address 0 = width, address 1 = height, addresses 2.. = width*height pixel words, row-major.
- Sits between the asset/UART/host loader and the dual-port sprite memory; the pixel-fetch reader consumes the same memory.

Parameters:
- ADDR_W, 10, sprite memory address width.
- DATA_W, 16, word width of the stream and the memory.
- DEPTH, 1024, memory words; header + pixels must fit (width*height <= DEPTH-2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (0 = reset)
- start  input  1  single-cycle pulse; begins a new image load
- s_valid  input  1  stream word valid
- s_data  input  DATA_W  stream word
- s_ready  output  1  loader can accept s_data this cycle
- wr_en  output  1  memory write strobe
- wr_addr  output  ADDR_W  memory write address
- wr_data  output  DATA_W  memory write data
- sprite_width  output  16  latched width of the current/last image
- sprite_height  output  16  latched height of the current/last image
- busy  output  1  high from accepted start until DONE/ERR
- done  output  1  one-cycle pulse, coincident with the final pixel write
- err  output  1  sticky error flag; cleared by rst or accepted start

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; s_ready, wr_en, busy, done, err = 0; wr_addr, wr_data, sprite_width, sprite_height, and the pixel counter = 0. Applies mid-load too: the partial image is abandoned and no further writes occur.
- States: IDLE, HDR_W, HDR_H, PIXELS, ERR.
- IDLE/ERR: s_ready = 0. start=1 -> HDR_W; err cleared, busy = 1, word index = 0.
- start is ignored in HDR_W, HDR_H, and PIXELS. No restart while busy.
- Transfer occurs when s_valid & s_ready. s_ready = 1 in HDR_W, HDR_H, and PIXELS. s_ready is a registered state decode and does not depend on s_valid.
- Latency: a word accepted at edge N appears as wr_en=1, wr_addr=index, wr_data=word in the cycle after edge N. wr_en = 0 in every cycle without a preceding transfer. Gaps in s_valid produce gaps in wr_en, with no address advance.
- HDR_W: on transfer, write addr 0, latch sprite_width, -> HDR_H.
- HDR_H: on transfer, write addr 1 and latch sprite_height.
  - Compute the 32-bit product width*height (full precision, no truncation).
  - If width==0, height==0, or product > DEPTH-2: -> ERR. err=1 and busy=0 in the same cycle as the addr-1 write.
  - Otherwise load remaining = product -> PIXELS.
- PIXELS: each transfer writes addr 2+k (k = 0..product-1) and decrements remaining.
  - On the final pixel transfer: -> IDLE; s_ready drops on the following cycle. No extra word is accepted.
  - done=1 and busy drops in the same cycle as the last write.
- wr_addr never exceeds DEPTH-1, and no write wraps; this is guaranteed by the size check.
- sprite_width and sprite_height hold until the next load's header overwrites them. They are not cleared by start.
- err holds until the next accepted start or reset. done never asserts on an erroring load.

Test Plan:
- 2x2 load: start; stream 0x0002,0x0002,0xAAAA,0xBBBB,0xCCCC,0xDDDD back-to-back -> writes addr 0..5 with those values on consecutive cycles. done=1 with the addr-5 write. Width/height = 2/2; err=0.
- Backpressure/gaps: same image with s_valid toggled 1,0,1,0,... -> identical write sequence, with wr_en low in gap cycles and wr_addr unchanged across gaps. done with addr 5.
- Size limits: 2x511 (1022 px) -> last write addr 1023, done=1. 32x32 (1024) -> err=1 after addr-1 write, s_ready=0, no addr>=2 writes, no done.
- Zero dimension: width 0x0000, height 0x0010 -> err=1; a subsequent start plus a valid 1x1 image (0x0001,0x0001,0x1234) -> err clears, addr 2 = 0x1234, done=1.
- start pulses at several points in PIXELS -> ignored; load completes normally with exactly product+2 writes.
- Reset mid-load (rst=0 after 3 pixels of a 4x4) -> next cycle wr_en=0, busy=0, width/height=0, s_ready=0. No writes until a new start.

Source files
------------

// File: rtl/sprite_loader.sv
// Sprite image writer: takes a valid/ready word stream (width, height, pixels)
// and writes it row-major into sprite memory, one registered write per word.
module sprite_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [15:0]       sprite_width,
  output logic [15:0]       sprite_height,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_W,
    HDR_H,
    PIXELS,
    ERR
  } state_t;

  state_t            state_q;
  logic              s_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [15:0]       width_q;
  logic [15:0]       height_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] rem_q;

  logic        xfer;
  logic [15:0] word_d;
  logic [31:0] prod_d;
  logic        size_bad_d;

  assign xfer   = s_valid & s_ready_q;
  assign word_d = s_data[15:0];
  // Full 32-bit product so huge headers cannot alias into a legal size
  assign prod_d = {16'd0, width_q} * {16'd0, word_d};
  assign size_bad_d = (width_q == 16'd0) || (word_d == 16'd0) ||
                      (prod_d > 32'(DEPTH - 2));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      width_q   <= '0;
      height_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      rem_q     <= '0;
    end else begin
      wr_en_q <= xfer;
      done_q  <= 1'b0;
      if (xfer) begin
        wr_addr_q <= idx_q;
        wr_data_q <= s_data;
        idx_q     <= idx_q + 1'b1;
      end
      unique case (state_q)
        IDLE, ERR: begin
          if (start) begin
            state_q   <= HDR_W;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            idx_q     <= '0;
          end
        end
        HDR_W: begin
          if (xfer) begin
            width_q <= word_d;
            state_q <= HDR_H;
          end
        end
        HDR_H: begin
          if (xfer) begin
            height_q <= word_d;
            if (size_bad_d) begin
              state_q   <= ERR;
              err_q     <= 1'b1;
              busy_q    <= 1'b0;
              s_ready_q <= 1'b0;
            end else begin
              rem_q   <= prod_d[ADDR_W-1:0];
              state_q <= PIXELS;
            end
          end
        end
        PIXELS: begin
          if (xfer) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == ADDR_W'(1)) begin
              state_q   <= IDLE;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              s_ready_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready       = s_ready_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign sprite_width  = width_q;
  assign sprite_height = height_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
